bisc_sng: RTL and testbench

- Binary-to-stochastic converter (SNG) feeding the stream datapath; the opposite end of the ones-accumulating counter.
- Latches an N-bit binary value and emits a deterministic, low-discrepancy bitstream of exactly 2^N bits in which exactly `value` bits are 1.
- Bit k is 1 when bitrev(k) < value.
- A downstream accumulator driven with enable=bit_valid and bit_in=bit_out recovers `value` exactly.

---
 rtl/bisc_sng_if.sv | 26 ++
 rtl/bisc_sng.sv | 85 ++++++++
 tb/tb_bisc_sng.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bisc_sng_if.sv
// Control/stream bundle for the binary-to-stochastic converter.
// start: sampled only in IDLE/DONE; stall: holds idx when high in STREAM; abort: wins over stall and start.
interface bisc_sng_if #(
  parameter int IN_BIN_LEN = 8
);
  logic                  start;
  logic [IN_BIN_LEN-1:0] value_in;
  logic                  stall;
  logic                  abort;
  logic                  bit_out;
  logic                  bit_valid;
  logic                  busy;
  logic                  done;
  logic [IN_BIN_LEN-1:0] bit_idx;
  logic [1:0]            state_dbg;

  modport master (
    output start, value_in, stall, abort,
    input  bit_out, bit_valid, busy, done, bit_idx, state_dbg
  );

  modport slave (
    input  start, value_in, stall, abort,
    output bit_out, bit_valid, busy, done, bit_idx, state_dbg
  );
endinterface

// File: rtl/bisc_sng.sv
// Binary-to-stochastic converter: emits 2^N bits where bit k = (bitrev(k) < value),
// giving a low-discrepancy stream with exactly `value` ones.
module bisc_sng #(
  parameter int IN_BIN_LEN = 8
) (
  input  logic       clock,
  input  logic       reset,
  bisc_sng_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IN_BIN_LEN-1:0] IDX_LAST = '1;

  state_t                state_q, state_d;
  logic [IN_BIN_LEN-1:0] val_q, val_d;
  logic [IN_BIN_LEN-1:0] idx_q, idx_d;
  logic [IN_BIN_LEN-1:0] idx_rev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < IN_BIN_LEN; i++) idx_rev[i] = idx_q[IN_BIN_LEN-1-i];
  end

  // Termination is detected at all-ones before incrementing, so idx never wraps.
  always_comb begin
    state_d       = state_q;
    val_d         = val_q;
    idx_d         = idx_q;
    bus.busy      = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_out   = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          val_d   = bus.value_in;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        bus.busy      = 1'b1;
        bus.bit_valid = !bus.stall;
        bus.bit_out   = (idx_rev < val_q);
        if (bus.abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (!bus.stall) begin
          if (idx_q == IDX_LAST) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          val_d   = bus.value_in;
          idx_d   = '0;
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bit_idx   = idx_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_bisc_sng.sv
// Bench for bisc_sng: an N=4 instance driven from a vector table and an N=8
// instance for abort and long streams; stream bits are checked from an expected queue.
module tb_bisc_sng;
  localparam int N4 = 4;
  localparam int N8 = 8;

  typedef struct {
    logic [3:0]  val;
    logic [15:0] pat;      // pat[k] is the expected bit at position k
    int          st_lo;
    int          st_hi;
    int          st2;
    int          jk_lo;
    int          jk_hi;
    bit          chain;
    int          done_cyc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bisc_sng_if #(.IN_BIN_LEN(N4)) if4 ();
  bisc_sng_if #(.IN_BIN_LEN(N8)) if8 ();

  bisc_sng #(.IN_BIN_LEN(N4)) dut4 (.clock(clock), .reset(reset), .bus(if4.slave));
  bisc_sng #(.IN_BIN_LEN(N8)) dut8 (.clock(clock), .reset(reset), .bus(if8.slave));

  int errors = 0;
  int checks = 0;
  logic [N4:0] exp4_q[$];
  logic [N8:0] exp8_q[$];
  int ones4 = 0;
  int ones8 = 0;
  int done4_cnt = 0;
  int done8_cnt = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Scoreboard side: every valid bit pops {k, bit} and is counted like a downstream accumulator.
  always @(negedge clock) begin
    logic [N4:0] e4;
    logic [N8:0] e8;
    if (if4.bit_valid === 1'b1) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4 unexpected bit: k=%0d bit=%0d with empty queue", if4.bit_idx, if4.bit_out);
      end else begin
        e4 = exp4_q.pop_front();
        check("dut4 {k,bit}", {27'd0, if4.bit_idx, if4.bit_out}, {27'd0, e4});
      end
      ones4 += int'(if4.bit_out);
    end
    if (if4.done === 1'b1) begin
      done4_cnt++;
      check("dut4 busy during done", {31'd0, if4.busy}, 32'd0);
    end
    if (if8.bit_valid === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8 unexpected bit: k=%0d bit=%0d with empty queue", if8.bit_idx, if8.bit_out);
      end else begin
        e8 = exp8_q.pop_front();
        check("dut8 {k,bit}", {23'd0, if8.bit_idx, if8.bit_out}, {23'd0, e8});
      end
      ones8 += int'(if8.bit_out);
    end
    if (if8.done === 1'b1) done8_cnt++;
  end

  task automatic push4(input logic [15:0] pat, input int nbits);
    logic [N4-1:0] kk;
    for (int k = 0; k < nbits; k++) begin
      kk = k[N4-1:0];
      exp4_q.push_back({kk, pat[k]});
    end
  endtask

  task automatic push8(input logic [7:0] val, input int nbits, output int cnt);
    logic [7:0] kk;
    logic       b;
    cnt = 0;
    for (int k = 0; k < nbits; k++) begin
      kk = k[7:0];
      b  = (bitrev8(kk) < val);
      cnt += int'(b);
      exp8_q.push_back({kk, b});
    end
  endtask

  // Called just after a rising edge; leaves time just after the start edge.
  task automatic start4(input logic [3:0] val);
    if4.value_in = val;
    if4.start    = 1'b1;
    @(posedge clock); #1;
    if4.start    = 1'b0;
  endtask

  task automatic start8(input logic [7:0] val);
    if8.value_in = val;
    if8.start    = 1'b1;
    @(posedge clock); #1;
    if8.start    = 1'b0;
  endtask

  // Cycle c is the c-th cycle after the start edge.
  task automatic run4(input vec_t v, input logic [3:0] next_val, input string tag);
    bit seen;
    seen = 0;
    for (int cyc = 1; cyc <= 80 && !seen; cyc++) begin
      if4.stall = ((cyc >= v.st_lo) && (cyc <= v.st_hi)) || (cyc == v.st2);
      if ((cyc >= v.jk_lo) && (cyc <= v.jk_hi)) begin
        if4.start    = 1'b1;
        if4.value_in = 4'hC;
      end else begin
        if4.start = 1'b0;
      end
      @(negedge clock);
      if (if4.done === 1'b1) begin
        seen = 1;
        check({tag, " done cycle"}, cyc, v.done_cyc);
        check({tag, " ones count"}, ones4, {28'd0, v.val});
        check({tag, " queue drained"}, exp4_q.size(), 32'd0);
        ones4 = 0;
        if (v.chain) begin
          if4.start    = 1'b1;
          if4.value_in = next_val;
        end
      end
      @(posedge clock); #1;
    end
    if4.start = 1'b0;
    if4.stall = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s done: not seen within 80 cycles", tag);
    end
  endtask

  task automatic run8(input int exp_ones, input string tag);
    bit seen;
    seen = 0;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(negedge clock);
      if (if8.done === 1'b1) begin
        seen = 1;
        check({tag, " done cycle"}, cyc, 32'd257);
        check({tag, " ones count"}, ones8, exp_ones);
        check({tag, " queue drained"}, exp8_q.size(), 32'd0);
        ones8 = 0;
      end
      @(posedge clock); #1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s done: not seen within 400 cycles", tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[8];
    vec_t rec;
    int   cnt;
    int   rv;

    tab[0] = '{4'd5,  16'h1115, 0, -1, 0,  0, -1, 1'b0, 17};
    tab[1] = '{4'd0,  16'h0000, 0, -1, 0,  0, -1, 1'b0, 17};
    tab[2] = '{4'd15, 16'h7FFF, 0, -1, 0,  0, -1, 1'b0, 17};
    tab[3] = '{4'd9,  16'h5557, 4,  6, 19, 0, -1, 1'b0, 21};
    tab[4] = '{4'd7,  16'h1555, 0, -1, 0,  0, -1, 1'b1, 17};
    tab[5] = '{4'd3,  16'h0111, 0, -1, 0,  3,  5, 1'b0, 17};
    tab[6] = '{4'd8,  16'h5555, 0, -1, 0,  0, -1, 1'b0, 17};
    tab[7] = '{4'd1,  16'h0001, 0, -1, 0,  0, -1, 1'b0, 17};

    if4.start = 1'b0; if4.value_in = '0; if4.stall = 1'b0; if4.abort = 1'b0;
    if8.start = 1'b0; if8.value_in = '0; if8.stall = 1'b0; if8.abort = 1'b0;

    // Reset state, with stall asserted to show it has no effect outside STREAM.
    if4.stall = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy",      {31'd0, if4.busy},      32'd0);
    check("reset bit_valid", {31'd0, if4.bit_valid}, 32'd0);
    check("reset done",      {31'd0, if4.done},      32'd0);
    check("reset bit_out",   {31'd0, if4.bit_out},   32'd0);
    check("reset bit_idx",   {28'd0, if4.bit_idx},   32'd0);
    check("reset state",     {30'd0, if4.state_dbg}, 32'd0);
    check("reset dut8 busy", {31'd0, if8.busy},      32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("idle with stall busy", {31'd0, if4.busy}, 32'd0);
    if4.stall = 1'b0;

    for (int i = 0; i < 8; i++) begin
      push4(tab[i].pat, 16);
      if (i == 0 || !tab[i-1].chain) start4(tab[i].val);
      run4(tab[i], (i < 7) ? tab[i+1].val : 4'd0, $sformatf("row%0d", i));
    end

    // Asynchronous reset between edges while k=6 is being presented.
    push4(16'h5777, 6);
    start4(4'd11);
    repeat (6) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async rst busy",      {31'd0, if4.busy},      32'd0);
    check("async rst bit_valid", {31'd0, if4.bit_valid}, 32'd0);
    check("async rst done",      {31'd0, if4.done},      32'd0);
    check("async rst bit_out",   {31'd0, if4.bit_out},   32'd0);
    check("async rst bit_idx",   {28'd0, if4.bit_idx},   32'd0);
    check("async rst queue",     exp4_q.size(),          32'd0);
    ones4 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("post rst idle busy", {31'd0, if4.busy}, 32'd0);
    push4(16'h5777, 16);
    start4(4'd11);
    rec = '{4'd11, 16'h5777, 0, -1, 0, 0, -1, 1'b0, 17};
    run4(rec, 4'd0, "after reset");
    check("dut4 done pulses", done4_cnt, 32'd9);

    // Abort at k=100, with a simultaneous start that must be ignored.
    push8(8'd200, 101, cnt);
    start8(8'd200);
    repeat (100) @(posedge clock);
    #1;
    if8.abort    = 1'b1;
    if8.start    = 1'b1;
    if8.value_in = 8'd50;
    @(posedge clock); #1;
    if8.abort = 1'b0;
    if8.start = 1'b0;
    check("abort busy",      {31'd0, if8.busy},      32'd0);
    check("abort bit_valid", {31'd0, if8.bit_valid}, 32'd0);
    check("abort done",      {31'd0, if8.done},      32'd0);
    check("abort bit_idx",   {24'd0, if8.bit_idx},   32'd0);
    check("abort state",     {30'd0, if8.state_dbg}, 32'd0);
    check("abort queue",     exp8_q.size(),          32'd0);
    check("abort ones",      ones8,                  cnt);
    ones8 = 0;
    repeat (3) @(posedge clock);
    #1;
    check("abort no done", done8_cnt, 32'd0);

    push8(8'd200, 256, cnt);
    check("model ones 200", cnt, 32'd200);
    start8(8'd200);
    run8(200, "n8 v200");

    push8(8'd255, 256, cnt);
    start8(8'd255);
    run8(255, "n8 v255");

    for (int r = 0; r < 2; r++) begin
      rv = $urandom_range(1, 254);
      push8(rv[7:0], 256, cnt);
      start8(rv[7:0]);
      run8(rv, $sformatf("n8 rand%0d", rv));
    end
    check("dut8 done pulses", done8_cnt, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
